// File: rtl/ram_arbiter.sv
// Round-robin arbiter sharing one single-port synchronous RAM between two requesters,
// with an optional lock and tagged read-data return.
module ram_arbiter #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 8
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_req0,
    input  logic              i_req1,
    input  logic              i_we0,
    input  logic              i_we1,
    input  logic              i_lock0,
    input  logic              i_lock1,
    input  logic [ADDR_W-1:0] i_addr0,
    input  logic [ADDR_W-1:0] i_addr1,
    input  logic [DATA_W-1:0] i_wdata0,
    input  logic [DATA_W-1:0] i_wdata1,
    output logic              o_gnt0,
    output logic              o_gnt1,
    output logic              o_rvalid0,
    output logic              o_rvalid1,
    output logic [DATA_W-1:0] o_rdata,
    output logic              o_ram_ce,
    output logic              o_ram_we,
    output logic [ADDR_W-1:0] o_ram_addr,
    output logic [DATA_W-1:0] o_ram_wdata,
    input  logic [DATA_W-1:0] i_ram_rdata
);

    logic              last_gnt_q, last_gnt_d;
    logic              lock_q, lock_d;
    logic              lock_owner_q, lock_owner_d;

    logic              ram_ce_q, ram_we_q;
    logic [ADDR_W-1:0] ram_addr_q;
    logic [DATA_W-1:0] ram_wdata_q;

    logic              rd_v1_q, rd_id1_q, rd_v2_q, rd_id2_q;
    logic              rvalid0_q, rvalid1_q;
    logic [DATA_W-1:0] rdata_q;

    logic              gnt0, gnt1, gnt_any, owner_req;
    logic              sel_we, sel_lock;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;

    // When the lock owner has dropped its request the lock is treated as gone,
    // so plain round-robin lets the other requester in during the same cycle.
    always_comb begin
        gnt0      = 1'b0;
        gnt1      = 1'b0;
        owner_req = lock_owner_q ? i_req1 : i_req0;
        if (!i_rst_n) begin
            gnt0 = 1'b0;
            gnt1 = 1'b0;
        end else if (lock_q && owner_req) begin
            gnt0 = ~lock_owner_q;
            gnt1 = lock_owner_q;
        end else if (i_req0 && i_req1) begin
            gnt0 = last_gnt_q;
            gnt1 = ~last_gnt_q;
        end else begin
            gnt0 = i_req0;
            gnt1 = i_req1;
        end
    end

    assign gnt_any   = gnt0 | gnt1;
    assign sel_we    = gnt1 ? i_we1    : i_we0;
    assign sel_lock  = gnt1 ? i_lock1  : i_lock0;
    assign sel_addr  = gnt1 ? i_addr1  : i_addr0;
    assign sel_wdata = gnt1 ? i_wdata1 : i_wdata0;

    // A locked cycle without a grant can only mean the owner went idle, which releases it.
    always_comb begin
        last_gnt_d   = last_gnt_q;
        lock_d       = 1'b0;
        lock_owner_d = lock_owner_q;
        if (gnt_any) begin
            last_gnt_d   = gnt1;
            lock_d       = sel_lock;
            lock_owner_d = gnt1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            last_gnt_q   <= 1'b1;
            lock_q       <= 1'b0;
            lock_owner_q <= 1'b0;
        end else begin
            last_gnt_q   <= last_gnt_d;
            lock_q       <= lock_d;
            lock_owner_q <= lock_owner_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            ram_ce_q    <= 1'b0;
            ram_we_q    <= 1'b0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
        end else begin
            ram_ce_q <= gnt_any;
            ram_we_q <= gnt_any & sel_we;
            if (gnt_any) begin
                ram_addr_q  <= sel_addr;
                ram_wdata_q <= sel_we ? sel_wdata : '0;
            end
        end
    end

    // Tag pipeline: stage 1 aligns with the RAM port, stage 2 with i_ram_rdata.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            rd_v1_q   <= 1'b0;
            rd_id1_q  <= 1'b0;
            rd_v2_q   <= 1'b0;
            rd_id2_q  <= 1'b0;
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
            rdata_q   <= '0;
        end else begin
            rd_v1_q   <= gnt_any & ~sel_we;
            rd_id1_q  <= gnt1;
            rd_v2_q   <= rd_v1_q;
            rd_id2_q  <= rd_id1_q;
            rvalid0_q <= rd_v2_q & ~rd_id2_q;
            rvalid1_q <= rd_v2_q & rd_id2_q;
            if (rd_v2_q) begin
                rdata_q <= i_ram_rdata;
            end
        end
    end

    assign o_gnt0      = gnt0;
    assign o_gnt1      = gnt1;
    assign o_rvalid0   = rvalid0_q;
    assign o_rvalid1   = rvalid1_q;
    assign o_rdata     = rdata_q;
    assign o_ram_ce    = ram_ce_q;
    assign o_ram_we    = ram_we_q;
    assign o_ram_addr  = ram_addr_q;
    assign o_ram_wdata = ram_wdata_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a behavioural 64x8 synchronous RAM on its port.
module tb_ram_arbiter;

    logic       clk;
    logic       rst_n;
    logic       req0, req1, we0, we1, lock0, lock1;
    logic [5:0] addr0, addr1;
    logic [7:0] wdata0, wdata1;
    logic       gnt0, gnt1, rvalid0, rvalid1;
    logic [7:0] rdata;
    logic       ram_ce, ram_we;
    logic [5:0] ram_addr;
    logic [7:0] ram_wdata;
    logic [7:0] ram_rdata;
    logic [7:0] mem [0:63];

    int total = 0;
    int bad   = 0;

    ram_arbiter #(.ADDR_W(6), .DATA_W(8)) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_req0(req0), .i_req1(req1),
        .i_we0(we0), .i_we1(we1),
        .i_lock0(lock0), .i_lock1(lock1),
        .i_addr0(addr0), .i_addr1(addr1),
        .i_wdata0(wdata0), .i_wdata1(wdata1),
        .o_gnt0(gnt0), .o_gnt1(gnt1),
        .o_rvalid0(rvalid0), .o_rvalid1(rvalid1),
        .o_rdata(rdata),
        .o_ram_ce(ram_ce), .o_ram_we(ram_we),
        .o_ram_addr(ram_addr), .o_ram_wdata(ram_wdata),
        .i_ram_rdata(ram_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_ce) begin
            if (ram_we) mem[ram_addr] <= ram_wdata;
            else        ram_rdata <= mem[ram_addr];
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end else begin
            $display("chk  %s: %0h", tag, got);
        end
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle_regs(input string tag);
        check({tag, "_ce"}, ram_ce, 0);
        check({tag, "_we"}, ram_we, 0);
        check({tag, "_addr"}, ram_addr, 0);
        check({tag, "_wdata"}, ram_wdata, 0);
        check({tag, "_rv0"}, rvalid0, 0);
        check({tag, "_rv1"}, rvalid1, 0);
        check({tag, "_rdata"}, rdata, 0);
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 8'h00;
        mem[1] = 8'h11; mem[2] = 8'h22; mem[5] = 8'h55; mem[6] = 8'h66; mem[6'h20] = 8'h77;
        ram_rdata = 8'h00;

        // Reset with both requests high
        rst_n = 0;
        req0 = 1; we0 = 1; lock0 = 0; addr0 = 6'h10; wdata0 = 8'hA5;
        req1 = 1; we1 = 0; lock1 = 0; addr1 = 6'h20; wdata1 = 8'h00;
        for (int i = 0; i < 3; i++) begin
            mid();
            check("rst_gnt0", gnt0, 0);
            check("rst_gnt1", gnt1, 0);
            if (i == 2) check_idle_regs("rst");
            nxt();
        end

        // First grant after release goes to requester 0 (write A5 -> 0x10)
        rst_n = 1;
        mid(); check("first_gnt0", gnt0, 1); check("first_gnt1", gnt1, 0);
        nxt(); req0 = 0;
        mid(); check("r1_gnt1", gnt1, 1);
        check("wr_ce", ram_ce, 1); check("wr_we", ram_we, 1);
        check("wr_addr", ram_addr, 6'h10); check("wr_wdata", ram_wdata, 8'hA5);
        nxt(); req1 = 0;
        mid(); check("rd1_ce", ram_ce, 1); check("rd1_we", ram_we, 0);
        check("rd1_addr", ram_addr, 6'h20); check("rd1_wdata", ram_wdata, 0);
        nxt();
        mid(); check("rd1_early_rv1", rvalid1, 0);
        nxt();
        mid(); check("rd1_rv1", rvalid1, 1); check("rd1_rv0", rvalid0, 0); check("rd1_data", rdata, 8'h77);
        nxt();

        // Single read of 0x10 by requester 0
        req0 = 1; we0 = 0; addr0 = 6'h10;
        mid(); check("sr_gnt0", gnt0, 1);
        nxt(); req0 = 0;
        mid(); check("sr_ce", ram_ce, 1); check("sr_addr", ram_addr, 6'h10);
        nxt();
        mid(); check("sr_n2_rv0", rvalid0, 0);
        nxt();
        mid(); check("sr_rv0", rvalid0, 1); check("sr_rv1", rvalid1, 0); check("sr_data", rdata, 8'hA5);
        nxt();
        mid(); check("sr_rv0_drop", rvalid0, 0); check("sr_data_hold", rdata, 8'hA5);
        nxt();

        // Write from req1 immediately followed by read from req0 at the same address
        req1 = 1; we1 = 1; addr1 = 6'h3F; wdata1 = 8'h3C;
        mid(); check("wr_gnt1", gnt1, 1);
        nxt(); req1 = 0; req0 = 1; we0 = 0; addr0 = 6'h3F;
        mid(); check("wr_rd_gnt0", gnt0, 1);
        nxt(); req0 = 0;
        nxt();
        nxt();
        mid(); check("wr_rd_rv0", rvalid0, 1); check("wr_rd_data", rdata, 8'h3C);
        nxt();

        // Lock: req0 holds the RAM for two locked reads then an unlocking write
        req0 = 1; we0 = 0; lock0 = 1; addr0 = 6'h05;
        mid(); check("lk_gnt0_a", gnt0, 1);
        nxt(); addr0 = 6'h06;
        req1 = 1; we1 = 1; lock1 = 0; addr1 = 6'h06; wdata1 = 8'h99;
        mid(); check("lk_gnt0_b", gnt0, 1); check("lk_gnt1_b", gnt1, 0);
        nxt(); we0 = 1; lock0 = 0; addr0 = 6'h05; wdata0 = 8'h5A;
        mid(); check("lk_gnt0_c", gnt0, 1); check("lk_gnt1_c", gnt1, 0);
        nxt(); req0 = 0;
        mid(); check("lk_gnt1_d", gnt1, 1); check("lk_gnt0_d", gnt0, 0);
        check("lk_rv0_a", rvalid0, 1); check("lk_data_a", rdata, 8'h55);
        nxt(); req1 = 0;
        mid(); check("lk_rv0_b", rvalid0, 1); check("lk_data_b", rdata, 8'h66);
        nxt();
        mid(); check("lk_mem5", mem[5], 8'h5A); check("lk_mem6", mem[6], 8'h99);
        nxt();

        // Contention: both read for 6 cycles, grants alternate starting with 0
        req0 = 1; we0 = 0; lock0 = 0; addr0 = 6'h01;
        req1 = 1; we1 = 0; lock1 = 0; addr1 = 6'h02;
        for (int k = 0; k < 11; k++) begin
            if (k == 6) begin req0 = 0; req1 = 0; end
            mid();
            if (k < 6) begin
                check($sformatf("ct_gnt0_%0d", k), gnt0, (k % 2 == 0));
                check($sformatf("ct_gnt1_%0d", k), gnt1, (k % 2 == 1));
            end
            if (k >= 3 && k < 9) begin
                check($sformatf("ct_rv0_%0d", k), rvalid0, ((k - 3) % 2 == 0));
                check($sformatf("ct_rv1_%0d", k), rvalid1, ((k - 3) % 2 == 1));
                check($sformatf("ct_data_%0d", k), rdata, ((k - 3) % 2 == 0) ? 8'h11 : 8'h22);
            end else if (k >= 9) begin
                check($sformatf("ct_rvnone_%0d", k), {rvalid1, rvalid0}, 0);
            end
            nxt();
        end

        // Lock released by owner dropping its request; other side granted same cycle
        req1 = 1; we1 = 0; lock1 = 1; addr1 = 6'h02;
        mid(); check("ld_gnt1", gnt1, 1);
        nxt(); req1 = 0; req0 = 1; we0 = 0; lock0 = 0; addr0 = 6'h01;
        mid(); check("ld_gnt0", gnt0, 1);
        nxt(); req0 = 0;
        nxt();
        mid(); check("ld_rv1", rvalid1, 1); check("ld_data1", rdata, 8'h22);
        nxt();
        mid(); check("ld_rv0", rvalid0, 1); check("ld_data0", rdata, 8'h11);
        nxt();

        // Reset while a read is in flight
        req0 = 1; we0 = 0; addr0 = 6'h01;
        mid(); check("mr_gnt0", gnt0, 1);
        nxt(); rst_n = 0; req1 = 1;
        mid(); check("mr_rst_gnt0", gnt0, 0); check("mr_rst_gnt1", gnt1, 0);
        nxt(); rst_n = 1; req0 = 0; req1 = 0;
        mid(); check_idle_regs("mr");
        for (int k = 0; k < 3; k++) begin
            nxt();
            mid(); check($sformatf("mr_rvnone_%0d", k), {rvalid1, rvalid0}, 0);
        end
        nxt(); req0 = 1; req1 = 1;
        mid(); check("mr_after_gnt0", gnt0, 1); check("mr_after_gnt1", gnt1, 0);
        nxt(); req0 = 0; req1 = 0;
        nxt();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
